// File: rtl/cpu_input_vector_loader.sv
// cpu_input_vector_loader
//
// Packs a stream of WORD_W-bit words, LSB-first, into a registered VEC_W-bit
// vector. The vector is then offered to the per-bit evaluators over a
// valid/ready handshake. A frame that has been offered is never retracted. The
// next fill starts only after the consumer has taken the frame.
//
// Optional feature macro: LOADER_PARITY_EN
//   When defined, each accepted word is checked for even parity against
//   in_par. A frame that contains any bad word is dropped at its last word,
//   and err pulses for one cycle.
//   When undefined, in_par is ignored and err stays low.
//
// Outputs in_ready and vec_valid come straight from flops, so there is no
// combinational path from in_valid or vec_ready to them.

module cpu_input_vector_loader #(
    parameter  int VEC_W   = 1894,
    parameter  int WORD_W  = 32,
    localparam int N_WORDS = (VEC_W + WORD_W - 1) / WORD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_par,
    input  logic              flush,
    output logic              vec_valid,
    input  logic              vec_ready,
    output logic [VEC_W-1:0]  vec,
    output logic [5:0]        word_cnt,
    output logic              err
);

    // state  | meaning
    // S_FILL | accepting words into vec, vec_valid low
    // S_FULL | complete frame offered, input stalled
    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(N_WORDS - 1);

    state_t             state_q;
    logic [5:0]         word_cnt_q;
    logic               in_ready_q;
    logic               vec_valid_q;
    logic               err_q;
    logic               par_flag_q;
    logic [VEC_W-1:0]   vec_q;
    logic [VEC_W-1:0]   vec_d;

    logic               word_hs;
    logic               word_wr;
    logic               word_bad;
    logic               frame_bad;
    logic               last_word;

    // in_ready_q is only high in S_FILL, so a handshake always belongs to a fill.
    assign word_hs   = in_valid & in_ready_q;
    assign word_wr   = word_hs & ~flush;
    assign last_word = (word_cnt_q == LAST_IDX);

`ifdef LOADER_PARITY_EN
    // The word plus its parity bit must XOR to zero (even parity).
    assign word_bad = ^{in_data, in_par};
`else
    logic unused_par;
    assign unused_par = in_par;
    assign word_bad   = 1'b0;
`endif

    // The frame is bad if an earlier word failed or the current word fails.
    assign frame_bad = par_flag_q | word_bad;

    // Each word slot owns a disjoint slice of the vector. The last slot is
    // clipped to the bits that remain, and its upper input bits are ignored.
    for (genvar w = 0; w < N_WORDS; w++) begin : g_slot
        localparam int LO = w * WORD_W;
        localparam int SW = ((VEC_W - LO) < WORD_W) ? (VEC_W - LO) : WORD_W;

        assign vec_d[LO +: SW] = (word_wr && (word_cnt_q == 6'(w)))
                                 ? in_data[SW-1:0]
                                 : vec_q[LO +: SW];
    end

    // Vector storage: update only the slot being written, keep the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q <= '0;
        end else begin
            vec_q <= vec_d;
        end
    end

    // Fill/offer sequencer with registered handshake outputs and the err pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FILL;
            word_cnt_q  <= '0;
            in_ready_q  <= 1'b1;
            vec_valid_q <= 1'b0;
            err_q       <= 1'b0;
            par_flag_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_FILL: begin
                    if (flush) begin
                        // Flush wins over a word arriving in the same cycle.
                        word_cnt_q <= '0;
                        par_flag_q <= 1'b0;
                    end else if (word_hs) begin
                        if (last_word) begin
                            word_cnt_q <= '0;
                            par_flag_q <= 1'b0;
                            if (frame_bad) begin
                                // Drop the frame and restart the fill.
                                err_q <= 1'b1;
                            end else begin
                                state_q     <= S_FULL;
                                in_ready_q  <= 1'b0;
                                vec_valid_q <= 1'b1;
                            end
                        end else begin
                            word_cnt_q <= word_cnt_q + 6'd1;
                            par_flag_q <= frame_bad;
                        end
                    end
                end
                S_FULL: begin
                    // Flush is ignored here; only consumer acceptance releases the frame.
                    if (vec_ready) begin
                        state_q     <= S_FILL;
                        in_ready_q  <= 1'b1;
                        vec_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= S_FILL;
                    in_ready_q  <= 1'b1;
                    vec_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign vec_valid = vec_valid_q;
    assign vec       = vec_q;
    assign word_cnt  = word_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cpu_input_vector_loader.sv
// Testbench for cpu_input_vector_loader: directed steps plus random word
// streams. Expected values come from a frame-level reference model.
module tb_cpu_input_vector_loader;

    localparam int VEC_W  = 1894;
    localparam int WORD_W = 32;
    localparam int NW     = 60;

`ifdef LOADER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_par;
    logic              flush;
    logic              vec_valid;
    logic              vec_ready;
    logic [VEC_W-1:0]  vec;
    logic [5:0]        word_cnt;
    logic              err;

    cpu_input_vector_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_par    (in_par),
        .flush     (flush),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec       (vec),
        .word_cnt  (word_cnt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: words of the frame in progress and the frame on offer.
    logic [31:0]      m_words [NW];
    logic [VEC_W-1:0] exp_vec = '0;
    bit               m_full  = 1'b0;
    int               m_cnt   = 0;
    bit               m_flag  = 1'b0;
    bit               err_exp = 1'b0;
    int               frames_done = 0;

    // Build the expected vector: bit j comes from word j/32, bit j%32.
    function automatic logic [VEC_W-1:0] pack_frame();
        logic [VEC_W-1:0] r;
        for (int j = 0; j < VEC_W; j++) r[j] = m_words[j / 32][j % 32];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag);
        total++;
        assert (vec === exp_vec) else begin
            bad++;
            $error("FAIL %s observed lo=%h hi=%h expected lo=%h hi=%h",
                   tag, vec[31:0], vec[VEC_W-1:VEC_W-32], exp_vec[31:0], exp_vec[VEC_W-1:VEC_W-32]);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic cycle(input logic iv, input logic [31:0] d, input logic p,
                         input logic fl, input logic vr);
        bit wbad;
        in_valid  = iv;
        in_data   = d;
        in_par    = p;
        flush     = fl;
        vec_ready = vr;
        @(posedge clk);
        err_exp = 1'b0;
        if (!m_full) begin
            if (fl) begin
                m_cnt  = 0;
                m_flag = 1'b0;
            end else if (iv) begin
                m_words[m_cnt] = d;
                wbad = PAR_EN && ((^d) != p);
                if (m_cnt == NW - 1) begin
                    m_cnt = 0;
                    if (m_flag || wbad) begin
                        m_flag  = 1'b0;
                        err_exp = 1'b1;
                    end else begin
                        m_full  = 1'b1;
                        exp_vec = pack_frame();
                        frames_done++;
                    end
                end else begin
                    m_cnt++;
                    m_flag = m_flag || wbad;
                end
            end
        end else if (vr) begin
            m_full = 1'b0;
        end
        @(negedge clk);
        chk("in_ready",  32'(in_ready),  32'(!m_full));
        chk("vec_valid", 32'(vec_valid), 32'(m_full));
        chk("word_cnt",  32'(word_cnt),  32'(m_cnt));
        chk("err",       32'(err),       32'(err_exp));
        chk("cnt_range", 32'(word_cnt <= 6'd59), 32'd1);
        if (m_full) chk_vec("vec");
    endtask

    task automatic send(input logic [31:0] d);
        cycle(1'b1, d, ^d, 1'b0, 1'b1);
    endtask

    task automatic send_vr(input logic [31:0] d, input logic vr);
        cycle(1'b1, d, ^d, 1'b0, vr);
    endtask

    task automatic idle(input logic vr);
        cycle(1'b0, $urandom, 1'b0, 1'b0, vr);
    endtask

    // Pulse reset asynchronously between clock edges and check its effect at once.
    task automatic async_reset(input string tag);
        in_valid = 1'b0;
        flush    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
        chk({tag, "_vec_valid"}, 32'(vec_valid), 32'd0);
        chk({tag, "_word_cnt"},  32'(word_cnt),  32'd0);
        chk({tag, "_err"},       32'(err),       32'd0);
        exp_vec = '0;
        chk_vec({tag, "_vec"});
        m_full  = 1'b0;
        m_cnt   = 0;
        m_flag  = 1'b0;
        err_exp = 1'b0;
        #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int target;
        logic [31:0] d;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_par    = 1'b0;
        flush     = 1'b0;
        vec_ready = 1'b0;

        async_reset("rst0");

        // Back-to-back fill with a known ramp.
        for (int k = 0; k < NW; k++) send(32'h0000_0100 + 32'(k));
        chk("t1_vld", 32'(vec_valid), 32'd1);
        chk("t1_lo",  vec[31:0], 32'h0000_0100);
        chk("t1_hi",  32'(vec[1893:1888]), 32'h3B);
        idle(1'b1);
        chk("t1_rdy", 32'(in_ready), 32'd1);

        // Backpressure: the frame holds while extra words are presented.
        for (int k = 0; k < NW; k++) send_vr($urandom, 1'b0);
        for (int k = 0; k < 20; k++) send_vr($urandom, 1'b0);
        chk("t2_hold_cnt", 32'(word_cnt), 32'd0);
        idle(1'b1);
        chk("t2_accept", 32'(vec_valid), 32'd0);

        // Random gaps on both handshakes over three frames.
        target = frames_done + 3;
        for (int c = 0; c < 3000 && frames_done < target; c++) begin
            d = $urandom;
            cycle(1'($urandom_range(0, 1)), d, ^d, 1'b0, 1'($urandom_range(0, 1)));
        end
        chk("t3_frames", 32'(frames_done >= target), 32'd1);
        idle(1'b0);
        cycle(1'b0, $urandom, 1'b0, 1'b1, 1'b0); // flush while full is ignored
        idle(1'b1);

        // Flush coinciding with word 30.
        for (int k = 0; k < 30; k++) send($urandom);
        d = 32'hDEAD_0030;
        cycle(1'b1, d, ^d, 1'b1, 1'b1);
        chk("t4_cnt", 32'(word_cnt), 32'd0);
        for (int k = 0; k < NW; k++) send(32'hA500_0000 + 32'(k));
        chk("t4_vld", 32'(vec_valid), 32'd1);
        idle(1'b1);

        // Reset mid-fill, then reset while full, then a clean fill.
        for (int k = 0; k < 45; k++) send($urandom);
        chk("t5_cnt45", 32'(word_cnt), 32'd45);
        async_reset("t5_mid");
        for (int k = 0; k < NW; k++) send_vr($urandom, 1'b0);
        async_reset("t5_full");
        for (int k = 0; k < NW; k++) send($urandom);
        chk("t5_vld", 32'(vec_valid), 32'd1);
        idle(1'b1);

        // Bad parity on word 10.
        for (int k = 0; k < NW; k++) begin
            d = $urandom;
            if (k == 10) cycle(1'b1, d, ~(^d), 1'b0, 1'b1);
            else         send(d);
        end
        chk("t6_vld", 32'(vec_valid), 32'(!PAR_EN));
        chk("t6_err", 32'(err), 32'(PAR_EN));
        idle(1'b1);
        chk("t6_err_clr", 32'(err), 32'd0);
        for (int k = 0; k < NW; k++) send($urandom);
        chk("t6_next", 32'(vec_valid), 32'd1);
        idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_input_vector_loader.md
# cpu_input_vector_loader

Builds the 1894-bit CPU-cluster input vector that the per-bit `module_output_bit_*` evaluators consume. Narrow words arrive over a valid/ready stream and are packed LSB-first into a registered wide vector. A complete vector is presented on a valid/ready output handshake. The vector stays stable until the consumer accepts it. The block is the writer side of the wide `i[1893:0]` bus that the evaluators read.

## Interface
Parameters:
- `VEC_W`, 1894, width of the assembled vector.
- `WORD_W`, 32, width of each input word.
- `N_WORDS`, ceil(VEC_W/WORD_W) = 60, words per vector (derived, not overridable).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  loader can accept a word.
- `in_data`  in  WORD_W  input word.
- `in_par`  in  1  even-parity bit over `in_data`; used only with `LOADER_PARITY_EN`.
- `flush`  in  1  synchronous abort of the current fill.
- `vec_valid`  out  1  `vec` holds a complete frame.
- `vec_ready`  in  1  consumer accepts `vec`.
- `vec`  out  VEC_W  assembled vector, registered; drives the evaluators' `i`.
- `word_cnt`  out  6  index of the next word slot, 0..N_WORDS-1.
- `err`  out  1  one-cycle pulse when a frame is discarded for parity.

## Operation
- States:
  - FILL: `in_ready`=1, `vec_valid`=0.
  - FULL: `in_ready`=0, `vec_valid`=1.
- Word handshake = `in_valid & in_ready`.
- On each word handshake in FILL, word k = `word_cnt` is written to `vec[k*WORD_W +: WORD_W]`, clipped to VEC_W.
  - For the last word (k=59), only bits [5:0] are used (1894-1888=6). Bits [31:6] are ignored.
- Counter behaviour:
  - `word_cnt` increments on each word handshake.
  - On the handshake at k=N_WORDS-1 it wraps to 0 and the state goes to FULL.
- FULL → FILL on `vec_valid & vec_ready`. `vec` keeps its contents until overwritten word by word.
- Bits of `vec` not yet rewritten in the current fill hold previous-frame values. Consumers read `vec` only while `vec_valid`=1.
- `flush` in FILL:
  - `word_cnt` goes to 0 and state stays FILL.
  - A word handshaken in the same cycle is discarded (flush wins).
- `flush` in FULL is ignored. A frame that has been offered is never retracted.
- No combinational path from `in_valid` to `in_ready` or from `vec_ready` to `vec_valid`.

## Timing
- Reset values: state=FILL, `in_ready`=1, `vec_valid`=0, `word_cnt`=0, `err`=0, `vec`=all zeros.
- `vec_valid` rises the cycle after the last-word handshake, giving a latency of 1 cycle from final word to frame.
- Minimum frame period is N_WORDS+1 = 61 cycles: 60 word cycles plus 1 FULL cycle with `vec_ready` held high.
- `in_ready` rises the cycle after `vec` is accepted. There is no word acceptance in the cycle of acceptance.
- `in_valid` and `in_data` may toggle without a handshake. Only handshake cycles update state.
- Reset asserted mid-fill or in FULL:
  - Immediate return to reset values.
  - A partial frame is lost.
  - `vec_valid` drops asynchronously.

## Configuration
- `LOADER_PARITY_EN` defined:
  - Each handshaken word is checked: `^{in_data, in_par}` must be 0.
  - A mismatch sets a sticky internal flag for the current frame.
  - On the last-word handshake with the flag set:
    - The frame is discarded: state stays FILL and `word_cnt`=0.
    - `err` pulses high for 1 cycle, the cycle after.
    - The flag clears.
  - `flush` also clears the flag.
- Undefined:
  - `in_par` is unused.
  - `err` is tied 0.
  - Every complete frame is offered.

## Test plan
- Reset, then 60 back-to-back words with word k = 32'h0000_0100+k, `vec_ready`=1.
  - `vec_valid` is high exactly 1 cycle after word 59.
  - `vec[31:0]`=32'h100 and `vec[1893:1888]`=6'h3B.
  - `in_ready` returns the following cycle.
- Fill a frame with `vec_ready`=0 for 20 cycles.
  - `vec_valid` and `vec` hold stable.
  - `in_ready`=0 and extra `in_valid` words are not consumed.
  - Raising `vec_ready` gives acceptance in 1 cycle.
- Random `in_valid` gaps (50% duty) over 3 frames → each vector matches a reference pack. `word_cnt` never exceeds 59.
- `flush` together with word 30's handshake.
  - `word_cnt`=0 next cycle.
  - Word 30 is dropped.
  - A subsequent 60-word fill produces a correct frame.
- `rst_n` low while `word_cnt`=45 → all outputs return to reset values asynchronously. A new full fill succeeds.
- `LOADER_PARITY_EN`: bad parity on word 10.
  - No `vec_valid` after word 59.
  - `err` is high 1 cycle, then the next good frame is offered normally.
  - Without the macro, the same stimulus yields a frame and `err`=0.
